alu_uart_frontend: RTL

Sequential front-end that drives the team's combinational ALU from a byte stream and returns its outputs as bytes. It sits between the UART receiver/transmitter pair and the ALU. It collects operand A, operand B and the op code from three received bytes, presents them to the ALU, and captures the result and flags. It then hands two bytes, the result and a flags byte, to the UART transmitter using a start/done handshake.

---
 rtl/alu_uart_frontend.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_uart_frontend.sv
// Byte-stream front end for the combinational ALU.
// Collects A, B and op code over UART rx, returns result and flags over tx.
module alu_uart_frontend #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    input  logic                  i_tx_done,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_rx_drop
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_TX_RES,
        SEND_FLG,
        WAIT_TX_FLG
    } state_t;

    state_t state, next_state;

    logic [NB_DATA-1:0]    data_a, data_a_d;
    logic [NB_DATA-1:0]    data_b, data_b_d;
    logic [NB_OP_CODE-1:0] op_code, op_code_d;
    logic [NB_DATA-1:0]    tx_data, tx_data_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic                  tx_start, tx_start_d;
    logic                  busy, busy_d;
    logic                  rx_drop, rx_drop_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= WAIT_A;
            data_a   <= '0;
            data_b   <= '0;
            op_code  <= '0;
            tx_data  <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            rx_drop  <= 1'b0;
        end else begin
            state    <= next_state;
            data_a   <= data_a_d;
            data_b   <= data_b_d;
            op_code  <= op_code_d;
            tx_data  <= tx_data_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            tx_start <= tx_start_d;
            busy     <= busy_d;
            rx_drop  <= rx_drop_d;
        end
    end

    // tx_data and tx_start are loaded on the edge entering a SEND state,
    // so the start pulse and its byte appear together during that state.
    always_comb begin
        next_state = state;
        data_a_d   = data_a;
        data_b_d   = data_b;
        op_code_d  = op_code;
        tx_data_d  = tx_data;
        zero_d     = zero_q;
        carry_d    = carry_q;
        tx_start_d = 1'b0;
        rx_drop_d  = 1'b0;
        unique case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d   = i_rx_data;
                    next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d   = i_rx_data;
                    next_state = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_code_d  = i_rx_data[NB_OP_CODE-1:0];
                    next_state = EXEC;
                end
            end
            EXEC: begin
                tx_data_d  = i_alu_result;
                zero_d     = i_alu_zero;
                carry_d    = i_alu_carry;
                tx_start_d = 1'b1;
                next_state = SEND_RES;
            end
            SEND_RES: begin
                next_state = WAIT_TX_RES;
            end
            WAIT_TX_RES: begin
                if (i_tx_done) begin
                    tx_data_d  = {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
                    tx_start_d = 1'b1;
                    next_state = SEND_FLG;
                end
            end
            SEND_FLG: begin
                next_state = WAIT_TX_FLG;
            end
            WAIT_TX_FLG: begin
                if (i_tx_done) begin
                    next_state = WAIT_A;
                end
            end
            default: begin
                next_state = WAIT_A;
            end
        endcase
        if (i_rx_done && !(state inside {WAIT_A, WAIT_B, WAIT_OP})) begin
            rx_drop_d = 1'b1;
        end
        busy_d = (next_state != WAIT_A);
    end

    assign o_data_a   = data_a;
    assign o_data_b   = data_b;
    assign o_op_code  = op_code;
    assign o_tx_data  = tx_data;
    assign o_tx_start = tx_start;
    assign o_busy     = busy;
    assign o_rx_drop  = rx_drop;

endmodule
